// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - prefetch queue of {pc, instruction} pairs between fetch and decode (option: FETCH_BUFFER_BYPASS_EN)

package sp_pkg;
    parameter int ADDR_WIDTH = 32;
    parameter int DATA_WIDTH = 32;
endpackage

module fetch_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = sp_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sp_pkg::DATA_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [ADDR_WIDTH-1:0]      in_pc_i,
    input  logic [DATA_WIDTH-1:0]      in_instr_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    output logic [ADDR_WIDTH-1:0]      out_pc_o,
    output logic [DATA_WIDTH-1:0]      out_instr_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count;
    // Ready comes from registered occupancy only, so a full buffer refuses a push
    // even while decode is popping in the same cycle.
    assign in_ready_o = !full;

`ifdef FETCH_BUFFER_BYPASS_EN
    logic bypass;

    assign bypass      = empty && in_valid_i && !flush_i;
    assign out_valid_o = bypass || (!empty && !flush_i);
    assign out_pc_o    = bypass ? in_pc_i :
                         (out_valid_o ? pc_mem[rd_ptr] : '0);
    assign out_instr_o = bypass ? in_instr_i :
                         (out_valid_o ? instr_mem[rd_ptr] : '0);
    // A bypassed pair taken by decode straight away never touches storage.
    assign wr_en       = in_valid_i && !full && !flush_i && !(bypass && out_ready_i);
    assign rd_en       = out_valid_o && out_ready_i && !empty;
`else
    assign out_valid_o = !empty && !flush_i;
    assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr]    : '0;
    assign out_instr_o = out_valid_o ? instr_mem[rd_ptr] : '0;
    assign wr_en       = in_valid_i && !full && !flush_i;
    assign rd_en       = out_valid_o && out_ready_i;
`endif

    // Storage write; contents are don't-care until covered by count, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            pc_mem[wr_ptr]    <= in_pc_i;
            instr_mem[wr_ptr] <= in_instr_i;
        end
    end

    // Pointer and occupancy tracking; flush overrides any push or pop that cycle.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - randomized and directed self-checking bench for fetch_buffer

module tb_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic [31:0] in_pc_i;
    logic [31:0] in_instr_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_instr_o;
    logic        out_ready_i;
    logic [2:0]  count_o;
    logic        full_o;
    logic        empty_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];

`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    fetch_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_pc_i     (in_pc_i),
        .in_instr_i  (in_instr_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_pc_o    (out_pc_o),
        .out_instr_o (out_instr_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        in_valid_i  = v;
        in_pc_i     = pc;
        in_instr_i  = ins;
        out_ready_i = rdy;
        flush_i     = fl;
        #1;
    endtask

    // Compare outputs against the queue model mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit          byp;
        bit          ev;
        bit          er;
        logic [31:0] epc;
        logic [31:0] ein;
        @(negedge clk_i);
        byp = BYP && (q.size() == 0) && in_valid_i && !flush_i;
        ev  = byp || (q.size() != 0 && !flush_i);
        er  = q.size() < DEPTH;
        epc = byp ? in_pc_i    : (ev ? q[0].pc    : 32'h0);
        ein = byp ? in_instr_i : (ev ? q[0].instr : 32'h0);
        check("out_valid", out_valid_o, ev);
        check("out_pc",    out_pc_o,    epc);
        check("out_instr", out_instr_o, ein);
        check("in_ready",  in_ready_o,  er);
        check("count",     count_o,     q.size());
        check("full",      full_o,      q.size() == DEPTH);
        check("empty",     empty_o,     q.size() == 0);
        @(posedge clk_i);
        if (flush_i) begin
            q.delete();
        end else if (byp && out_ready_i) begin
            // pair consumed directly, queue untouched
        end else begin
            if (ev && out_ready_i) void'(q.pop_front());
            if (in_valid_i && er) q.push_back('{pc: in_pc_i, instr: in_instr_i});
        end
        #1;
    endtask

    initial begin
        arst_ni = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_ready", in_ready_o, 1);
        check("rst_valid", out_valid_o, 0);
        arst_ni = 1'b1;

        // Fill to full with decode stalled; the fifth pair must be refused.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(2 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h8, 32'hA4, 1'b0, 1'b0);
        check("fill_full", full_o, 1);
        check("fill_ready", in_ready_o, 0);
        tick();
        check("fill_count", count_o, 4);

        // Full plus a pop: push still refused that cycle.
        drive(1'b1, 32'h8, 32'hA4, 1'b1, 1'b0);
        check("drain_pc0", out_pc_o, 32'h0);
        check("drain_in0", out_instr_o, 32'hA0);
        tick();
        check("fullpop_count", count_o, 3);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            check("drain_pc", out_pc_o, 32'(2 * i));
            check("drain_instr", out_instr_o, 32'hA0 + 32'(i));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain_empty", empty_o, 1);
        check("drain_valid", out_valid_o, 0);
        tick();

        // Concurrent push/pop at count 2 across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 2; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hC0 + 32'(i), 1'b1, 1'b0);
            check("conc_pc", out_pc_o, 32'h100 + 32'(4 * (i - 2)));
            tick();
            check("conc_count", count_o, 2);
        end

        // Flush with a pair offered in the same cycle; that pair is dropped.
        drive(1'b1, 32'h200, 32'hD0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h10, 32'hEE, 1'b0, 1'b1);
        check("flush_valid", out_valid_o, 0);
        tick();
        check("flush_count", count_o, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("flush_nopc10", (out_valid_o && out_pc_o == 32'h10), 0);
        tick();

        // Push into an empty buffer with decode ready.
        drive(1'b1, 32'h20, 32'hF0, 1'b1, 1'b0);
        if (BYP) begin
            check("byp_valid", out_valid_o, 1);
            check("byp_pc", out_pc_o, 32'h20);
            tick();
            check("byp_count", count_o, 0);
        end else begin
            check("nobyp_valid0", out_valid_o, 0);
            tick();
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            check("nobyp_valid1", out_valid_o, 1);
            check("nobyp_pc", out_pc_o, 32'h20);
            tick();
        end

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {$urandom_range(0, 32767), 1'b0}, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            tick();
        end

        // Asynchronous reset mid-run with entries present.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(i), 32'h55, 1'b0, 1'b0);
            tick();
        end
        arst_ni = 1'b0;
        #1;
        q.delete();
        check("mrst_count", count_o, 0);
        check("mrst_empty", empty_o, 1);
        check("mrst_ready", in_ready_o, 1);
        check("mrst_valid", out_valid_o, 0);
        check("mrst_pc", out_pc_o, 0);
        @(posedge clk_i);
        #1;
        arst_ni = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
